// File: rtl/booth_pkg.sv
// Shared widths and Booth recode table for the radix-4 multiplier datapath and its controller.
package booth_pkg;

  localparam int unsigned N  = 8;
  localparam int unsigned AW = N + 2;
  localparam int unsigned CW = (N / 2 > 2) ? $clog2(N / 2) : 1;
  localparam int unsigned PW = 2 * N;

  // Strobe triple issued by the controller for one Booth window {Q[1], Q[0], Qm1}.
  typedef struct packed {
    logic add;  // c2
    logic dbl;  // c3
    logic sub;  // c4
  } booth_op_t;

  localparam booth_op_t OpNone   = '{add: 1'b0, dbl: 1'b0, sub: 1'b0};
  localparam booth_op_t OpPlusM  = '{add: 1'b1, dbl: 1'b0, sub: 1'b0};
  localparam booth_op_t OpPlus2M = '{add: 1'b1, dbl: 1'b1, sub: 1'b0};
  localparam booth_op_t OpMinus2M = '{add: 1'b1, dbl: 1'b1, sub: 1'b1};
  localparam booth_op_t OpMinusM = '{add: 1'b1, dbl: 1'b0, sub: 1'b1};

  function automatic booth_op_t booth_recode(input logic [2:0] win);
    booth_op_t op;
    unique case (win)
      3'b001, 3'b010: op = OpPlusM;
      3'b011:         op = OpPlus2M;
      3'b100:         op = OpMinus2M;
      3'b101, 3'b110: op = OpMinusM;
      default:        op = OpNone;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_radix4_datapath_if.sv
// Strobe/status bundle between the Booth controller (master) and datapath (slave).
interface booth_radix4_datapath_if;
  import booth_pkg::*;

  logic [N-1:0]  inbus;
  logic          c0, c1, c2, c3, c4, c5, c6;
  logic          q1, q0, q;
  logic          is_count_3;
  logic [PW-1:0] prod;

  modport master (
    output inbus, c0, c1, c2, c3, c4, c5, c6,
    input  q1, q0, q, is_count_3, prod
  );

  modport slave (
    input  inbus, c0, c1, c2, c3, c4, c5, c6,
    output q1, q0, q, is_count_3, prod
  );

endinterface

// File: rtl/booth_addsub.sv
// Combinational (N+2)-bit accumulator update: A +/- M or A +/- 2M, modulo 2^(N+2).
module booth_addsub
  import booth_pkg::*;
(
  input  logic [AW-1:0] a,
  input  logic [N-1:0]  m,
  input  logic          c3,
  input  logic          c4,
  output logic [AW-1:0] sum
);

  logic [AW-1:0] operand;

  always_comb begin
    operand = c3 ? {m[N-1], m, 1'b0} : {{2{m[N-1]}}, m};
    sum     = c4 ? (a - operand) : (a + operand);
  end

endmodule

// File: rtl/booth_radix4_datapath.sv
// Radix-4 Booth datapath: M/A/Q/Qm1 registers, 2-bit arithmetic shifter, iteration counter
// and product latch, driven by controller strobes c0..c6.
module booth_radix4_datapath
  import booth_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_b,
  booth_radix4_datapath_if.slave   bus
);

  localparam logic [CW-1:0] LastCnt = CW'(N / 2 - 1);
  localparam int unsigned   SW      = AW + N + 1;

  logic [N-1:0]  m_q, m_d;
  logic [AW-1:0] a_q, a_d;
  logic [N-1:0]  q_q, q_d;
  logic          qm1_q, qm1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] prod_q, prod_d;

  logic [AW-1:0] a_sum;
  logic [SW+1:0] shift_in;

  booth_addsub u_addsub (
    .a   (a_q),
    .m   (m_q),
    .c3  (bus.c3),
    .c4  (bus.c4),
    .sum (a_sum)
  );

  // Two copies of the sign above A give the arithmetic shift by 2 over {A,Q,Qm1}.
  assign shift_in = {a_q[AW-1], a_q[AW-1], a_q, q_q, qm1_q};

  always_comb begin
    m_d    = bus.c0 ? bus.inbus : m_q;
    prod_d = bus.c6 ? {a_q[N-1:0], q_q} : prod_q;
    a_d    = a_q;
    q_d    = q_q;
    qm1_d  = qm1_q;
    cnt_d  = cnt_q;
    if (bus.c1) begin
      a_d   = '0;
      q_d   = bus.inbus;
      qm1_d = 1'b0;
      cnt_d = '0;
    end else if (bus.c2) begin
      // Add wins over shift; the shift and count step are dropped entirely.
      a_d = a_sum;
    end else if (bus.c5) begin
      a_d   = shift_in[SW+1:N+3];
      q_d   = shift_in[N+2:3];
      qm1_d = shift_in[2];
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m_q    <= '0;
      a_q    <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      cnt_q  <= '0;
      prod_q <= '0;
    end else begin
      m_q    <= m_d;
      a_q    <= a_d;
      q_q    <= q_d;
      qm1_q  <= qm1_d;
      cnt_q  <= cnt_d;
      prod_q <= prod_d;
    end
  end

  assign bus.q1         = q_q[1];
  assign bus.q0         = q_q[0];
  assign bus.q          = qm1_q;
  assign bus.is_count_3 = (cnt_q == LastCnt);
  assign bus.prod       = prod_q;

endmodule

// File: doc/booth_radix4_datapath.md
# booth_radix4_datapath

Datapath for the 8-bit signed radix-4 Booth multiplier. It sits directly beneath the multiplier control FSM: it consumes strobes c0..c6 and returns the Booth window bits (q1, q0, q) and the iteration flag (is_count_3). Operands arrive one per cycle on a shared input bus. The 2N-bit signed product is latched to a registered output.

## Interface
- N, 8, operand width in bits; must be even and at least 4; iteration count is N/2
- clk  in  1  clock, rising edge
- rst_b  in  1  asynchronous, active-low reset
- inbus  in  N  operand bus: multiplicand on c0, multiplier on c1
- c0  in  1  load M from inbus
- c1  in  1  load Q from inbus; clear A, Qm1 and cnt
- c2  in  1  add/subtract enable: A <= A ± (M or 2M)
- c3  in  1  select 2M (M sign-extended, shifted left 1) instead of M
- c4  in  1  subtract (two's complement of selected operand) instead of add
- c5  in  1  arithmetic shift {A,Q,Qm1} right by 2; cnt <= cnt+1
- c6  in  1  latch product {A[N-1:0], Q} into prod
- q1  out  1  Q[1]
- q0  out  1  Q[0]
- q  out  1  Qm1 (bit shifted out below Q)
- is_count_3  out  1  cnt == N/2-1
- prod  out  2N  signed product register

## Operation
- Registers:
  - M: N bits.
  - A: N+2 bits, signed accumulator; the extra 2 bits hold ±2M without overflow.
  - Q: N bits.
  - Qm1: 1 bit.
  - cnt: log2(N/2) bits, minimum 1 bit.
  - prod: 2N bits.
- c0: M <= inbus.
- c1: Q <= inbus; A <= 0; Qm1 <= 0; cnt <= 0.
- c2: operand = c3 ? sext(M)<<1 : sext(M), both N+2 bits.
  - A <= c4 ? A − operand : A + operand.
  - Arithmetic is modulo 2^(N+2). No overflow flag.
- c5: {A,Q,Qm1} <= {A[N+1],A[N+1],A,Q,Qm1} >> 2, i.e. arithmetic shift right by 2.
  - cnt <= cnt+1, wrapping N/2−1 → 0.
- c6: prod <= {A[N-1:0], Q}. Otherwise prod holds its value.
- Booth recoding is produced by the controller. This block only executes the strobes:
  - 000 / 111: no strobe
  - 001 / 010: c2 (+M)
  - 011: c2, c3 (+2M)
  - 100: c2, c3, c4 (−2M)
  - 101 / 110: c2, c4 (−M)
- Multiple strobes in one cycle:
  - c1 has priority over c2 and c5 on A, Q, Qm1 and cnt.
  - c2 has priority over c5 on A. When c2 and c5 are both asserted, the shift and the count increment are dropped.
  - c0 and c6 are independent of all other strobes.
  - The controller never issues these combinations; the bench checks that the priority holds anyway.
- c3 and c4 without c2: no effect.
- Reset values: M, A, Q, Qm1, cnt and prod all 0. Therefore q1 = q0 = q = 0. is_count_3 is 0 (1 only if N = 2, which is illegal).

## Timing
- All register updates occur on the clk rising edge after the strobe cycle.
- q1, q0, q and is_count_3 are combinational from registers, valid in the same cycle as the state they describe.
- Controller cycle sequence: c0, c1, then N/2 × (decode cycle, optional c2 cycle, c5 cycle), then c6.
- is_count_3 is sampled by the controller during the c5 cycle. The final shift wraps cnt to 0.
- Latency from the c1 edge to the prod update:
  - N/2 × 3 + 1 cycles in the controller's fixed-length schedule.
  - With N = 8: 13 cycles. prod is valid on the edge that ends the c6 cycle.
- Asynchronous reset mid-operation clears all registers immediately. The outputs go to their reset values with no clock required.
- A new c1 restarts accumulation without a reset. M and prod are retained.

## Structure
- Shared package booth_pkg holds:
  - N default
  - derived widths: AW = N+2, CW = log2(N/2), PW = 2N
  - the localparam encoding of the Booth recode table, shared with the controller
- One natural sub-module is booth_addsub: combinational (N+2)-bit adder/subtractor. Inputs are A, M, c3 and c4; output is the next A.
- Everything else (registers, shifter, counter, prod latch) lives in the top.

## Test plan
- Driving a full controller-shaped schedule with M=7, Q=3 gives prod = 16'd21. The observed q1, q0, q windows must be 110, 001, 000, 000.
- M=−128 (0x80), Q=−128 gives prod = 16'h4000 (16384). This covers the −2M path and A's extra width.
- M=127, Q=−128 gives prod = 16'hC080 (−16256). M=−1, Q=−1 gives prod = 16'h0001.
- Counter check:
  - is_count_3 is asserted only during the 4th c5 cycle.
  - After that shift cnt = 0.
  - A 5th c5 sets cnt = 1 and clears is_count_3.
- Strobes c2 and c5 asserted together with A=5 and M=3 (c3=c4=0): A becomes 8 with no shift and cnt unchanged. Strobes c1 and c2 asserted together: A = 0.
- Asserting rst_b low after the 2nd iteration clears all outputs, including prod = 0, before the next edge. A fresh run with M=−5, Q=9 then gives prod = 16'hFFD3 (−45).
